// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: state codes,
// reset vector default and the bubble word.
package if_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_WAIT = 2'd1;
  localparam fetch_state_t S_HOLD = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch bus bundle: instruction SRAM req/ack
// channel plus the word handed to IF/ID.
interface if_fetch_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_cur_instaddress;
  logic [31:0] if_next_instaddress;
  logic        if_valid;

  modport master (
    output inst_req, inst_addr,
    output if_inst, if_cur_instaddress,
    output if_next_instaddress, if_valid,
    input  inst_addr_ok, inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    input  if_inst, if_cur_instaddress,
    input  if_next_instaddress, if_valid,
    output inst_addr_ok, inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns PC, one outstanding
// SRAM read, delay-slot redirect, flush, stall.
// Ports: clk, rst (sync, high), stall_pc,
// flush_if/flush_target, branch_taken/
// branch_target, bus (if_fetch_if.master).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC =
    if_fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush_if,
  input  logic [31:0] flush_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  if_fetch_if.master  bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_seq;
  logic [31:0]  pc_adv;
  logic [31:0]  redir_target;
  logic [31:0]  buf_inst;
  logic [31:0]  word;
  logic         discard;
  logic         redir_pend;
  logic         deliver;
  logic         advance;

  assign pc_seq = pc + 32'd4;

  always_comb begin
    deliver = 1'b0;
    word    = NOP;
    if (state == S_WAIT) begin
      deliver = bus.inst_data_ok && !discard;
      word    = bus.inst_rdata;
    end else if (state == S_HOLD) begin
      deliver = 1'b1;
      word    = buf_inst;
    end
    if (rst || flush_if)
      deliver = 1'b0;
  end

  assign advance = deliver && !stall_pc;

  always_comb begin
    pc_adv = pc_seq;
    if (branch_taken)
      pc_adv = branch_target;
    else if (redir_pend)
      pc_adv = redir_target;
  end

  assign bus.inst_req  = !rst && (state == S_REQ);
  assign bus.inst_addr = rst ? RESET_PC : pc;
  assign bus.if_valid  = deliver;
  assign bus.if_inst   = deliver ? word : NOP;
  assign bus.if_cur_instaddress =
    deliver ? pc : 32'h0;
  assign bus.if_next_instaddress =
    deliver ? pc_seq : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= S_REQ;
      discard      <= 1'b0;
      redir_pend   <= 1'b0;
      redir_target <= 32'h0;
      buf_inst     <= 32'h0;
    end else if (flush_if) begin
      pc         <= flush_target;
      redir_pend <= 1'b0;
      // a read still in flight must be
      // swallowed when its data returns
      if ((state == S_WAIT && !bus.inst_data_ok) ||
          (state == S_REQ && bus.inst_addr_ok)) begin
        discard <= 1'b1;
        state   <= S_WAIT;
      end else begin
        discard <= 1'b0;
        state   <= S_REQ;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (bus.inst_addr_ok)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (!stall_pc) begin
              state <= S_REQ;
            end else begin
              buf_inst <= bus.inst_rdata;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_pc)
            state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
      if (advance) begin
        pc         <= pc_adv;
        redir_pend <= 1'b0;
      end else if (branch_taken) begin
        // delay slot not yet delivered
        redir_pend   <= 1'b1;
        redir_target <= branch_target;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed SRAM
// handshakes, stalls, redirects, flush, reset.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_pc = 1'b0;
  logic        flush_if = 1'b0;
  logic [31:0] flush_target = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;

  if_fetch_if bus();

  if_fetch dut (
    .clk(clk),
    .rst(rst),
    .stall_pc(stall_pc),
    .flush_if(flush_if),
    .flush_target(flush_target),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(string n,
                       logic [31:0] act,
                       logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL extra_delivery: got %h @%h want none",
                 bus.if_inst, bus.if_cur_instaddress);
      end else begin
        check("if_inst", bus.if_inst, sb[0].inst);
        check("if_cur", bus.if_cur_instaddress,
              sb[0].addr);
        check("if_next", bus.if_next_instaddress,
              sb[0].addr + 32'd4);
        if (!stall_pc)
          void'(sb.pop_front());
      end
    end else begin
      check("if_valid", 32'(bus.if_valid), 32'h0);
      check("bubble_inst", bus.if_inst, 32'h0);
      check("bubble_cur",
            bus.if_cur_instaddress, 32'h0);
      check("bubble_next",
            bus.if_next_instaddress, 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look(logic r, logic ca,
                      logic [31:0] a, string n);
    @(negedge clk);
    check({n, "_req"}, 32'(bus.inst_req), 32'(r));
    if (ca)
      check({n, "_addr"}, bus.inst_addr, a);
  endtask

  task automatic req(logic [31:0] a);
    bus.inst_addr_ok = 1'b1;
    look(1'b1, 1'b1, a, "req");
    cyc();
    bus.inst_addr_ok = 1'b0;
  endtask

  task automatic data(logic [31:0] d,
                      logic [31:0] a,
                      int stall_n,
                      logic br = 1'b0,
                      logic [31:0] tgt = 32'h0);
    sb.push_back(exp_t'{inst: d, addr: a});
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = d;
    stall_pc         = (stall_n > 0);
    branch_taken     = br;
    branch_target    = tgt;
    look(1'b0, 1'b0, 32'h0, "data");
    cyc();
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    branch_taken     = 1'b0;
    for (int i = 1; i < stall_n; i++) begin
      look(1'b0, 1'b0, 32'h0, "hold");
      cyc();
    end
    if (stall_n > 0) begin
      stall_pc = 1'b0;
      look(1'b0, 1'b0, 32'h0, "release");
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    cyc();
    look(1'b0, 1'b1, 32'hBFC00000, "reset");
    cyc();
    rst = 1'b0;

    req(32'hBFC00000);
    data(32'h24020001, 32'hBFC00000, 0);

    look(1'b1, 1'b1, 32'hBFC00004, "req_wait");
    cyc();
    req(32'hBFC00004);
    data(32'h3C011234, 32'hBFC00004, 3);

    req(32'hBFC00008);
    branch_taken  = 1'b1;
    branch_target = 32'hBFC00100;
    look(1'b0, 1'b0, 32'h0, "wait_br");
    cyc();
    branch_taken = 1'b0;
    data(32'h8C220010, 32'hBFC00008, 0);

    req(32'hBFC00100);
    flush_if     = 1'b1;
    flush_target = 32'hBFC00380;
    look(1'b0, 1'b0, 32'h0, "flush_wait");
    cyc();
    flush_if = 1'b0;
    look(1'b0, 1'b0, 32'h0, "flush_gap");
    cyc();
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEADBEEF;
    look(1'b0, 1'b0, 32'h0, "drop1");
    cyc();
    bus.inst_data_ok = 1'b0;
    req(32'hBFC00380);
    data(32'hAC430004, 32'hBFC00380, 0);

    branch_taken  = 1'b1;
    branch_target = 32'hBFC00200;
    look(1'b1, 1'b1, 32'hBFC00384, "req_br");
    cyc();
    branch_taken     = 1'b0;
    flush_if         = 1'b1;
    bus.inst_addr_ok = 1'b1;
    look(1'b1, 1'b1, 32'hBFC00384, "req_flush");
    cyc();
    flush_if         = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEADBEEF;
    look(1'b0, 1'b0, 32'h0, "drop2");
    cyc();
    bus.inst_data_ok = 1'b0;
    req(32'hBFC00380);
    data(32'h00851021, 32'hBFC00380, 0);

    req(32'hBFC00384);
    rst              = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEADBEEF;
    look(1'b0, 1'b1, 32'hBFC00000, "rst_wait");
    cyc();
    bus.inst_data_ok = 1'b0;
    look(1'b0, 1'b1, 32'hBFC00000, "rst_hold");
    cyc();
    rst = 1'b0;
    req(32'hBFC00000);
    data(32'h3C1DBFC1, 32'hBFC00000, 0,
         1'b1, 32'hBFC00500);
    req(32'hBFC00500);
    data(32'h24840001, 32'hBFC00500, 0);
    look(1'b1, 1'b1, 32'hBFC00504, "final");

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
